// File: rtl/pht_update_queue_pkg.sv
// Shared definitions for the PHT update path: table geometry, counter
// encodings and the layout of one pending write.
package pht_update_queue_pkg;

  localparam int PHT_IDX_W   = 11;
  localparam int PHT_CNT_W   = 2;
  localparam int PHT_ENTRIES = 2048;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } pht_cnt_e;

  typedef struct packed {
    logic [PHT_IDX_W-1:0] idx;
    logic [PHT_CNT_W-1:0] cnt;
  } pht_entry_t;

endpackage

// File: rtl/pht_update_queue_sat_cnt.sv
// Combinational saturating up/down counter step: taken moves toward the
// all-ones state, not-taken toward zero, and both ends hold.
module pht_sat_cnt #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] i_base,
  input  logic             i_taken,
  output logic [CNT_W-1:0] o_new
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = '0;

  // Step toward the resolved direction unless already saturated there.
  always_comb begin
    o_new = i_base;
    if (i_taken) begin
      if (i_base != CNT_MAX) o_new = i_base + CNT_W'(1);
    end else begin
      if (i_base != CNT_MIN) o_new = i_base - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pht_update_queue.sv
// Buffers resolved-branch counter updates ahead of the PHT write port.
// New counters are computed from the youngest queued value for the same
// index (or the prediction-time snapshot), no-op writes are dropped, and
// the head drains one entry per cycle unless the write port is stalled.
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = PHT_IDX_W,
  parameter int CNT_W = PHT_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_upd_vld,
  output logic                       o_upd_rdy,
  input  logic [IDX_W-1:0]           i_upd_idx,
  input  logic                       i_upd_taken,
  input  logic [CNT_W-1:0]           i_upd_cnt,
  input  logic                       i_pht_wr_stall,
  output logic                       o_pht_wren,
  output logic [IDX_W-1:0]           o_pht_widx,
  output logic [CNT_W-1:0]           o_pht_wr_entry,
  output logic [$clog2(DEPTH):0]     o_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [IDX_W-1:0] r_idx [DEPTH];
  logic [CNT_W-1:0] r_cnt [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_head_vld;
  logic [PTR_W-1:0] w_slot;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_new;
  logic             w_acc;
  logic             w_enq;
  logic             w_deq;
  logic [DEPTH-1:0] w_vld_nxt;

  assign w_head_vld     = r_vld[r_rd_ptr];
  assign o_pht_wren     = w_head_vld & ~i_pht_wr_stall;
  assign o_pht_widx     = w_head_vld ? r_idx[r_rd_ptr] : '0;
  assign o_pht_wr_entry = w_head_vld ? r_cnt[r_rd_ptr] : '0;
  assign o_upd_rdy      = (r_count != FULL_CNT);
  assign o_occupancy    = r_count;

  // Forwarding: walk entries oldest to youngest from the head so the last
  // match wins. The head is included even when it drains this cycle, since
  // the branch unit's snapshot predates that write.
  always_comb begin
    w_base = i_upd_cnt;
    w_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot = r_rd_ptr + PTR_W'(i);
      if (r_vld[w_slot] && (r_idx[w_slot] == i_upd_idx)) begin
        w_base = r_cnt[w_slot];
      end
    end
  end

  pht_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .i_base  (w_base),
    .i_taken (i_upd_taken),
    .o_new   (w_new)
  );

  assign w_acc = i_upd_vld & o_upd_rdy;
  assign w_enq = w_acc & (w_new != w_base);
  assign w_deq = o_pht_wren;

  // Next valid mask: retire the head, then claim the write slot.
  always_comb begin
    w_vld_nxt = r_vld;
    if (w_deq) w_vld_nxt[r_rd_ptr] = 1'b0;
    if (w_enq) w_vld_nxt[r_wr_ptr] = 1'b1;
  end

  // Queue control state: pointers, occupancy and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage; contents are only meaningful where valid.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_idx[r_wr_ptr] <= i_upd_idx;
      r_cnt[r_wr_ptr] <= w_new;
    end
  end

endmodule

// File: tb/tb_pht_update_queue.sv
// Self-checking bench for pht_update_queue: a scoreboard queue mirrors the
// FIFO contents, and a PHT array absorbs the writes the DUT issues.
module tb_pht_update_queue;
  import pht_update_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int IDX_W = 11;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_upd_vld = 1'b0;
  logic             o_upd_rdy;
  logic [IDX_W-1:0] i_upd_idx = '0;
  logic             i_upd_taken = 1'b0;
  logic [CNT_W-1:0] i_upd_cnt = '0;
  logic             i_pht_wr_stall = 1'b0;
  logic             o_pht_wren;
  logic [IDX_W-1:0] o_pht_widx;
  logic [CNT_W-1:0] o_pht_wr_entry;
  logic [2:0]       o_occupancy;

  always #5 clk = ~clk;

  pht_update_queue #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_upd_vld      (i_upd_vld),
    .o_upd_rdy      (o_upd_rdy),
    .i_upd_idx      (i_upd_idx),
    .i_upd_taken    (i_upd_taken),
    .i_upd_cnt      (i_upd_cnt),
    .i_pht_wr_stall (i_pht_wr_stall),
    .o_pht_wren     (o_pht_wren),
    .o_pht_widx     (o_pht_widx),
    .o_pht_wr_entry (o_pht_wr_entry),
    .o_occupancy    (o_occupancy)
  );

  int checks = 0;
  int errors = 0;

  pht_entry_t       sb[$];
  logic [IDX_W-1:0] wr_log[$];
  logic [CNT_W-1:0] pht_model [PHT_ENTRIES];
  logic [CNT_W-1:0] exp_pht   [PHT_ENTRIES];
  int               n_writes;
  int               n_pushes;

  logic             obs_rdy, obs_wren, obs_acc;
  logic [IDX_W-1:0] obs_widx;
  logic [CNT_W-1:0] obs_entry;
  logic [2:0]       obs_occ;

  function automatic logic [1:0] ref_sat(input logic [1:0] b, input logic t);
    if (t) return (b == 2'd3) ? 2'd3 : b + 2'd1;
    else   return (b == 2'd0) ? 2'd0 : b - 2'd1;
  endfunction

  // One clock of stimulus, entered and left at a falling edge. Checks the
  // DUT outputs against the scoreboard, then updates the scoreboard with
  // what the coming rising edge should do.
  task automatic cycle(input logic vld, input logic [IDX_W-1:0] idx,
                       input logic taken, input logic [1:0] cnt,
                       input logic stall);
    logic       exp_rdy, exp_wren;
    logic [1:0] base, nv;
    pht_entry_t e;
    i_upd_vld      = vld;
    i_upd_idx      = idx;
    i_upd_taken    = taken;
    i_upd_cnt      = cnt;
    i_pht_wr_stall = stall;
    #1;
    exp_rdy  = (sb.size() != DEPTH);
    exp_wren = (sb.size() != 0) && !stall;
    obs_rdy   = o_upd_rdy;
    obs_wren  = o_pht_wren;
    obs_widx  = o_pht_widx;
    obs_entry = o_pht_wr_entry;
    obs_occ   = o_occupancy;
    checks++;
    if (o_upd_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL sb_rdy t=%0t got %b expected %b", $time, o_upd_rdy, exp_rdy);
    end
    checks++;
    if (o_occupancy !== 3'(sb.size())) begin
      errors++;
      $display("FAIL sb_occupancy t=%0t got %0d expected %0d", $time, o_occupancy, sb.size());
    end
    checks++;
    if (o_pht_wren !== exp_wren) begin
      errors++;
      $display("FAIL sb_wren t=%0t got %b expected %b", $time, o_pht_wren, exp_wren);
    end
    if (sb.size() != 0) begin
      checks++;
      if ({o_pht_widx, o_pht_wr_entry} !== {sb[0].idx, sb[0].cnt}) begin
        errors++;
        $display("FAIL sb_head t=%0t got idx=%h cnt=%0d expected idx=%h cnt=%0d",
                 $time, o_pht_widx, o_pht_wr_entry, sb[0].idx, sb[0].cnt);
      end
    end else begin
      checks++;
      if ({o_pht_widx, o_pht_wr_entry} !== '0) begin
        errors++;
        $display("FAIL sb_empty_fields t=%0t got idx=%h cnt=%0d expected 0",
                 $time, o_pht_widx, o_pht_wr_entry);
      end
    end
    base = cnt;
    foreach (sb[k]) if (sb[k].idx == idx) base = sb[k].cnt;
    nv = ref_sat(base, taken);
    obs_acc = vld && exp_rdy;
    if (o_pht_wren === 1'b1) begin
      pht_model[o_pht_widx] = o_pht_wr_entry;
      wr_log.push_back(o_pht_widx);
      n_writes++;
    end
    if (exp_wren) void'(sb.pop_front());
    if (obs_acc && (nv != base)) begin
      e.idx = idx;
      e.cnt = nv;
      sb.push_back(e);
      exp_pht[idx] = nv;
      n_pushes++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) cycle(1'b0, '0, 1'b0, 2'd0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_upd_vld = 1'b0;
    i_pht_wr_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({o_pht_wren, o_upd_rdy, o_occupancy} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_state got wren=%b rdy=%b occ=%0d expected wren=0 rdy=1 occ=0",
               o_pht_wren, o_upd_rdy, o_occupancy);
    end
    checks++;
    if ({o_pht_widx, o_pht_wr_entry} !== '0) begin
      errors++;
      $display("FAIL reset_fields got idx=%h cnt=%0d expected 0", o_pht_widx, o_pht_wr_entry);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    cycle(1'b1, 11'h005, 1'b1, 2'd1, 1'b0);
    cycle(1'b0, '0, 1'b0, 2'd0, 1'b0);
    checks++;
    if ({obs_wren, obs_widx, obs_entry, obs_occ} !== {1'b1, 11'h005, 2'd2, 3'd1}) begin
      errors++;
      $display("FAIL single_write got wren=%b idx=%h cnt=%0d occ=%0d expected wren=1 idx=005 cnt=2 occ=1",
               obs_wren, obs_widx, obs_entry, obs_occ);
    end
    cycle(1'b0, '0, 1'b0, 2'd0, 1'b0);
    checks++;
    if ({obs_wren, obs_occ} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL single_after got wren=%b occ=%0d expected wren=0 occ=0", obs_wren, obs_occ);
    end
  endtask

  task automatic test_saturate();
    cycle(1'b1, 11'h010, 1'b1, 2'd3, 1'b0);
    checks++;
    if (obs_rdy !== 1'b1) begin
      errors++;
      $display("FAIL sat_up_rdy got %b expected 1", obs_rdy);
    end
    cycle(1'b1, 11'h011, 1'b0, 2'd0, 1'b0);
    checks++;
    if ({obs_wren, obs_occ, obs_rdy} !== {1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL sat_up_noenq got wren=%b occ=%0d rdy=%b expected wren=0 occ=0 rdy=1",
               obs_wren, obs_occ, obs_rdy);
    end
    cycle(1'b0, '0, 1'b0, 2'd0, 1'b0);
    checks++;
    if ({obs_wren, obs_occ} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL sat_dn_noenq got wren=%b occ=%0d expected wren=0 occ=0", obs_wren, obs_occ);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got [4];
    logic       gw  [4];
    for (int k = 0; k < 4; k++) begin
      if (k < 3) cycle(1'b1, 11'h7FF, 1'b1, 2'd0, 1'b0);
      else       cycle(1'b0, '0, 1'b0, 2'd0, 1'b0);
      got[k] = obs_entry;
      gw[k]  = obs_wren;
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if ({gw[k], got[k]} !== {1'b1, 2'(k)}) begin
        errors++;
        $display("FAIL b2b_write%0d got wren=%b cnt=%0d expected wren=1 cnt=%0d", k, gw[k], got[k], k);
      end
    end
    drain();
  endtask

  task automatic test_stall();
    bit accepted = 1'b0;
    wr_log.delete();
    for (int k = 0; k < 5; k++) cycle(1'b1, 11'h100 + 11'(k), 1'b1, 2'd1, 1'b1);
    checks++;
    if ({obs_rdy, obs_occ, obs_wren} !== {1'b0, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL stall_full got rdy=%b occ=%0d wren=%b expected rdy=0 occ=4 wren=0",
               obs_rdy, obs_occ, obs_wren);
    end
    for (int k = 0; k < 10 && !accepted; k++) begin
      cycle(1'b1, 11'h104, 1'b1, 2'd1, 1'b0);
      accepted = obs_acc;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL stall_fifth_accept got not-accepted expected accepted");
    end
    drain();
    checks++;
    if (wr_log.size() != 5) begin
      errors++;
      $display("FAIL stall_write_count got %0d expected 5", wr_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (wr_log[k] !== 11'h100 + 11'(k)) begin
          errors++;
          $display("FAIL stall_order%0d got %h expected %h", k, wr_log[k], 11'h100 + 11'(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) cycle(1'b1, 11'h200 + 11'(k), 1'b1, 2'd1, 1'b1);
    rst = 1'b1;
    i_upd_vld = 1'b1;
    i_upd_idx = 11'h300;
    i_upd_taken = 1'b1;
    i_upd_cnt = 2'd1;
    i_pht_wr_stall = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    wr_log.delete();
    cycle(1'b0, '0, 1'b0, 2'd0, 1'b0);
    checks++;
    if ({obs_occ, obs_wren, obs_rdy} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_state got occ=%0d wren=%b rdy=%b expected occ=0 wren=0 rdy=1",
               obs_occ, obs_wren, obs_rdy);
    end
    cycle(1'b0, '0, 1'b0, 2'd0, 1'b0);
    checks++;
    if (wr_log.size() != 0) begin
      errors++;
      $display("FAIL rstmid_no_write got %0d writes expected 0", wr_log.size());
    end
  endtask

  task automatic test_random();
    logic [IDX_W-1:0] idx;
    logic             taken;
    int               bad = 0;
    for (int k = 0; k < PHT_ENTRIES; k++) begin
      pht_model[k] = 2'd0;
      exp_pht[k]   = 2'd0;
    end
    n_writes = 0;
    n_pushes = 0;
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      if (k % 3 == 0) idx = 11'($urandom_range(0, PHT_ENTRIES - 1));
      else            idx = 11'h040 + 11'($urandom_range(0, 2));
      taken = (k == 4) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle(1'b1, idx, taken, pht_model[idx], 1'b0);
    end
    drain();
    for (int k = 0; k < PHT_ENTRIES; k++) if (pht_model[k] !== exp_pht[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_pht got %0d mismatching entries expected 0", bad);
    end
    checks++;
    if (n_writes != n_pushes) begin
      errors++;
      $display("FAIL random_write_count got %0d writes expected %0d", n_writes, n_pushes);
    end
  endtask

  initial begin
    n_writes = 0;
    n_pushes = 0;
    for (int k = 0; k < PHT_ENTRIES; k++) begin
      pht_model[k] = 2'd0;
      exp_pht[k]   = 2'd0;
    end
    @(negedge clk);
    test_reset();
    test_single();
    test_saturate();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
